// File: rtl/stk_pipe_lk.sv
// Stack pipeline lookup stage: free-list line allocation and SRAM/uc issue.
// Optional perf counters: define STK_PIPE_LK_PERF_EN.
module stk_pipe_lk #(
  parameter int BANKS_N = 4,
  parameter int LINES_N = 64,
  parameter int ENGS_N  = 4,
  parameter int DATA_W  = 128,
  localparam int LINE_W = $clog2(LINES_N),
  localparam int BANK_W = $clog2(BANKS_N),
  localparam int PTR_W  = BANK_W + LINE_W,
  localparam int ENG_W  = $clog2(ENGS_N)
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       i_cmd_vld,
  input  logic [ENG_W-1:0]           i_cmd_engid,
  input  logic                       i_cmd_pop,
  input  logic [DATA_W-1:0]          i_cmd_dat,
  output logic                       o_cmd_rdy,
  input  logic [BANKS_N*PTR_W-1:0]   i_lk_prev_ptr_dout_w,
  output logic [BANKS_N-1:0]         o_lk_prev_ptr_ce_r,
  output logic [BANKS_N-1:0]         o_lk_prev_ptr_oe_r,
  output logic [BANKS_N*LINE_W-1:0]  o_lk_prev_ptr_addr_r,
  output logic [BANKS_N*PTR_W-1:0]   o_lk_prev_ptr_din_r,
  output logic [BANKS_N-1:0]         o_lk_ptr_dat_ce_r,
  output logic [BANKS_N-1:0]         o_lk_ptr_dat_oe_r,
  output logic [BANKS_N*LINE_W-1:0]  o_lk_ptr_dat_addr_r,
  output logic [BANKS_N*DATA_W-1:0]  o_lk_ptr_dat_din_r,
  output logic                       o_mem_uc_vld_r,
  output logic [ENG_W-1:0]           o_mem_uc_engid_r,
  output logic [BANK_W-1:0]          o_mem_uc_bankid_r,
  output logic                       o_mem_uc_head_vld_r,
  output logic [PTR_W-1:0]           o_mem_uc_head_ptr_r,
  output logic                       o_mem_uc_tail_vld_r,
  output logic [PTR_W-1:0]           o_mem_uc_tail_ptr_r
`ifdef STK_PIPE_LK_PERF_EN
  ,
  output logic [31:0]                o_perf_push_r,
  output logic [31:0]                o_perf_pop_r,
  output logic [31:0]                o_perf_err_r
`endif
);

  localparam int FL_D = BANKS_N * LINES_N;

  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_POP_WAIT = 2'd2;
  localparam logic [1:0] ST_POP_UPD  = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] init_ptr;

  logic [PTR_W-1:0] fl_mem [FL_D];
  logic [PTR_W-1:0] fl_wp;
  logic [PTR_W-1:0] fl_rp;
  logic [PTR_W:0]   fl_cnt;

  logic [PTR_W-1:0] head  [ENGS_N];
  logic [PTR_W:0]   depth [ENGS_N];

  logic [ENG_W-1:0] pop_eng;
  logic [PTR_W-1:0] pop_ptr;

  logic              cmd_acc;
  logic              fl_empty;
  logic              fl_push;
  logic              fl_pop;
  logic [PTR_W-1:0]  fl_wdat;
  logic [PTR_W-1:0]  new_ptr;
  logic [BANK_W-1:0] new_bank;
  logic [LINE_W-1:0] new_line;
  logic [PTR_W-1:0]  cur_head;
  logic [PTR_W:0]    cur_depth;
  logic [BANK_W-1:0] hd_bank;
  logic [LINE_W-1:0] hd_line;
  logic              eng_empty;
  logic              do_push;
  logic              do_pop;
  logic              do_err;
  logic [BANK_W-1:0] pop_bank;
  logic [PTR_W-1:0]  upd_head;

  logic [BANKS_N-1:0]        nx_p_ce;
  logic [BANKS_N-1:0]        nx_p_oe;
  logic [BANKS_N*LINE_W-1:0] nx_p_addr;
  logic [BANKS_N*PTR_W-1:0]  nx_p_din;
  logic [BANKS_N-1:0]        nx_d_ce;
  logic [BANKS_N-1:0]        nx_d_oe;
  logic [BANKS_N*LINE_W-1:0] nx_d_addr;
  logic [BANKS_N*DATA_W-1:0] nx_d_din;
  logic [ENG_W-1:0]          nx_eng;
  logic [BANK_W-1:0]         nx_bank;
  logic                      nx_hv;
  logic [PTR_W-1:0]          nx_hp;
  logic                      nx_tv;
  logic [PTR_W-1:0]          nx_tp;

  assign o_cmd_rdy = (state == ST_IDLE);
  assign cmd_acc   = i_cmd_vld & o_cmd_rdy;

  assign fl_empty = (fl_cnt == '0);
  assign new_ptr  = fl_mem[fl_rp];
  assign new_bank = new_ptr[PTR_W-1:LINE_W];
  assign new_line = new_ptr[LINE_W-1:0];

  assign cur_head  = head[i_cmd_engid];
  assign cur_depth = depth[i_cmd_engid];
  assign eng_empty = (cur_depth == '0);
  assign hd_bank   = cur_head[PTR_W-1:LINE_W];
  assign hd_line   = cur_head[LINE_W-1:0];

  assign do_push = cmd_acc & ~i_cmd_pop & ~fl_empty;
  assign do_pop  = cmd_acc & i_cmd_pop & ~eng_empty;
  assign do_err  = cmd_acc & (i_cmd_pop ? eng_empty : fl_empty);

  // Refill happens only in INIT and POP_UPD, allocation only in IDLE.
  assign fl_push = (state == ST_INIT) | (state == ST_POP_UPD);
  assign fl_pop  = do_push;
  assign fl_wdat = (state == ST_INIT) ? init_ptr : pop_ptr;

  assign pop_bank = pop_ptr[PTR_W-1:LINE_W];
  assign upd_head = i_lk_prev_ptr_dout_w[pop_bank*PTR_W +: PTR_W];

  always_comb begin
    nx_p_ce   = '0;
    nx_p_oe   = '0;
    nx_p_addr = '0;
    nx_p_din  = '0;
    nx_d_ce   = '0;
    nx_d_oe   = '0;
    nx_d_addr = '0;
    nx_d_din  = '0;
    nx_eng    = cmd_acc ? i_cmd_engid : '0;
    nx_bank   = '0;
    nx_hv     = 1'b0;
    nx_hp     = '0;
    nx_tv     = 1'b0;
    nx_tp     = '0;
    unique case (1'b1)
      do_push: begin
        nx_bank = new_bank;
        nx_hv   = 1'b1;
        nx_hp   = new_ptr;
        nx_tv   = ~eng_empty;
        nx_tp   = cur_head;
        for (int b = 0; b < BANKS_N; b++) begin
          if (new_bank == BANK_W'(b)) begin
            nx_d_ce[b] = 1'b1;
            nx_d_addr[b*LINE_W +: LINE_W] = new_line;
            nx_d_din[b*DATA_W +: DATA_W]  = i_cmd_dat;
            nx_p_ce[b] = 1'b1;
            nx_p_addr[b*LINE_W +: LINE_W] = new_line;
            nx_p_din[b*PTR_W +: PTR_W]    = cur_head;
          end
        end
      end
      do_pop: begin
        nx_bank = hd_bank;
        nx_hv   = 1'b1;
        nx_hp   = cur_head;
        for (int b = 0; b < BANKS_N; b++) begin
          if (hd_bank == BANK_W'(b)) begin
            nx_d_ce[b] = 1'b1;
            nx_d_oe[b] = 1'b1;
            nx_d_addr[b*LINE_W +: LINE_W] = hd_line;
            nx_p_ce[b] = 1'b1;
            nx_p_oe[b] = 1'b1;
            nx_p_addr[b*LINE_W +: LINE_W] = hd_line;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_lk_prev_ptr_ce_r   <= '0;
      o_lk_prev_ptr_oe_r   <= '0;
      o_lk_prev_ptr_addr_r <= '0;
      o_lk_prev_ptr_din_r  <= '0;
      o_lk_ptr_dat_ce_r    <= '0;
      o_lk_ptr_dat_oe_r    <= '0;
      o_lk_ptr_dat_addr_r  <= '0;
      o_lk_ptr_dat_din_r   <= '0;
      o_mem_uc_vld_r       <= 1'b0;
      o_mem_uc_engid_r     <= '0;
      o_mem_uc_bankid_r    <= '0;
      o_mem_uc_head_vld_r  <= 1'b0;
      o_mem_uc_head_ptr_r  <= '0;
      o_mem_uc_tail_vld_r  <= 1'b0;
      o_mem_uc_tail_ptr_r  <= '0;
    end else begin
      o_lk_prev_ptr_ce_r   <= nx_p_ce;
      o_lk_prev_ptr_oe_r   <= nx_p_oe;
      o_lk_prev_ptr_addr_r <= nx_p_addr;
      o_lk_prev_ptr_din_r  <= nx_p_din;
      o_lk_ptr_dat_ce_r    <= nx_d_ce;
      o_lk_ptr_dat_oe_r    <= nx_d_oe;
      o_lk_ptr_dat_addr_r  <= nx_d_addr;
      o_lk_ptr_dat_din_r   <= nx_d_din;
      o_mem_uc_vld_r       <= cmd_acc;
      o_mem_uc_engid_r     <= nx_eng;
      o_mem_uc_bankid_r    <= nx_bank;
      o_mem_uc_head_vld_r  <= nx_hv;
      o_mem_uc_head_ptr_r  <= nx_hp;
      o_mem_uc_tail_vld_r  <= nx_tv;
      o_mem_uc_tail_ptr_r  <= nx_tp;
    end
  end

  always_ff @(posedge clk) begin
    if (fl_push) begin
      fl_mem[fl_wp] <= fl_wdat;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fl_wp  <= '0;
      fl_rp  <= '0;
      fl_cnt <= '0;
    end else begin
      if (fl_push) begin
        fl_wp <= fl_wp + 1'b1;
      end
      if (fl_pop) begin
        fl_rp <= fl_rp + 1'b1;
      end
      if (fl_push) begin
        fl_cnt <= fl_cnt + 1'b1;
      end else if (fl_pop) begin
        fl_cnt <= fl_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      pop_eng  <= '0;
      pop_ptr  <= '0;
      for (int i = 0; i < ENGS_N; i++) begin
        head[i]  <= '0;
        depth[i] <= '0;
      end
    end else begin
      unique case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == PTR_W'(FL_D - 1)) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (do_push) begin
            head[i_cmd_engid]  <= new_ptr;
            depth[i_cmd_engid] <= cur_depth + 1'b1;
          end
          if (do_pop) begin
            pop_eng <= i_cmd_engid;
            pop_ptr <= cur_head;
            state   <= ST_POP_WAIT;
          end
        end
        ST_POP_WAIT: begin
          state <= ST_POP_UPD;
        end
        ST_POP_UPD: begin
          // PREV read issued two cycles ago holds the next-older line.
          head[pop_eng]  <= upd_head;
          depth[pop_eng] <= depth[pop_eng] - 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef STK_PIPE_LK_PERF_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_perf_push_r <= '0;
      o_perf_pop_r  <= '0;
      o_perf_err_r  <= '0;
    end else begin
      if (do_push && (o_perf_push_r != '1)) begin
        o_perf_push_r <= o_perf_push_r + 1'b1;
      end
      if (do_pop && (o_perf_pop_r != '1)) begin
        o_perf_pop_r <= o_perf_pop_r + 1'b1;
      end
      if (do_err && (o_perf_err_r != '1)) begin
        o_perf_err_r <= o_perf_err_r + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/stk_pipe_lk.md
Name: stk_pipe_lk

Overview:
- Lookup (LK) stage of the stack pipeline: the initiator side of the memory stage's SRAM and LK-microcode interfaces.
- Accepts push/pop commands per engine and keeps per-engine head pointer and depth.
- Allocates and frees lines through an internal free list.
- Drives per-bank PREV-pointer and DATA SRAM strobes, and issues one memory microcode per command to the memory stage.

Parameters:
- BANKS_N, 4, SRAM banks; power of 2.
- LINES_N, 64, lines per bank; power of 2.
- ENGS_N, 4, engines (independent stacks).
- DATA_W, 128, data SRAM width.
- Derived: LINE_W=log2(LINES_N), BANK_W=log2(BANKS_N), PTR_W=BANK_W+LINE_W, ENG_W=log2(ENGS_N).
- Pointer encoding: ptr = {bank, line}.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_cmd_vld  in  1  command valid
- i_cmd_engid  in  ENG_W  target engine
- i_cmd_pop  in  1  1=pop, 0=push
- i_cmd_dat  in  DATA_W  push data
- o_cmd_rdy  out  1  command accepted when vld&rdy
- i_lk_prev_ptr_dout_w  in  BANKS_N*PTR_W  PREV SRAM read data, valid the cycle after a read strobe
- o_lk_prev_ptr_ce_r  out  BANKS_N  PREV chip enable
- o_lk_prev_ptr_oe_r  out  BANKS_N  1=read, 0=write (with ce)
- o_lk_prev_ptr_addr_r  out  BANKS_N*LINE_W  PREV address
- o_lk_prev_ptr_din_r  out  BANKS_N*PTR_W  PREV write data
- o_lk_ptr_dat_ce_r / _oe_r / _addr_r / _din_r  out  BANKS_N / BANKS_N / BANKS_N*LINE_W / BANKS_N*DATA_W  DATA SRAM, same rules as PREV
- o_mem_uc_vld_r  out  1  microcode valid
- o_mem_uc_engid_r  out  ENG_W  microcode engine
- o_mem_uc_bankid_r  out  BANK_W  microcode bank
- o_mem_uc_head_vld_r, o_mem_uc_head_ptr_r  out  1, PTR_W  line accessed
- o_mem_uc_tail_vld_r, o_mem_uc_tail_ptr_r  out  1, PTR_W  prior head linked on push

Behaviour:
- Reset: clk single clock, arst_n asynchronous active-low. All outputs 0; FSM=INIT; all engine depths 0; free list empty.
- INIT:
  - o_cmd_rdy=0.
  - One pointer per cycle, 0..BANKS_N*LINES_N-1, is written into the free-list FIFO (depth BANKS_N*LINES_N).
  - Moves to IDLE after the last pointer.
- IDLE: o_cmd_rdy=1. Accepted command at cycle T; all SRAM strobes and microcode are registered and visible at T+1 for exactly one cycle. Only the strobes of the addressed bank are asserted.
- Push, engine e, free list non-empty:
  - Pop free pointer n.
  - DATA write: ce=1, oe=0, addr=n.line, din=dat.
  - PREV write: addr=n.line, din=head[e].
  - uc: head_vld=1, head_ptr=n, tail_vld=(depth[e]!=0), tail_ptr=head[e], bankid=n.bank.
  - head[e]=n; depth[e]++.
  - Stays in IDLE (back-to-back pushes accepted every cycle).
- Push with free list empty:
  - No SRAM strobe; state unchanged.
  - uc issued with head_vld=0, tail_vld=0 (overflow).
- Pop, engine e, depth[e]!=0:
  - DATA and PREV reads (ce=1, oe=1) at addr=head[e].line.
  - uc: head_vld=1, head_ptr=head[e], tail_vld=0.
  - Go to POP_WAIT (rdy=0, T+1), then POP_UPD (rdy=0, T+2): head[e] is set from the PREV dout of bank head[e].bank, old head is pushed onto the free list, depth[e]--.
  - Return to IDLE at T+3.
- Pop on empty engine: no strobe; uc with head_vld=0; remains IDLE.
- Depth counters are PTR_W+1 bits. Free-list read/write pointers wrap modulo depth.
- Free-list push and pop never occur in the same cycle.
- Reset mid-operation aborts any pop and re-enters INIT.

Optional Feature:
- Macro STK_PIPE_LK_PERF_EN.
- Defined: adds o_perf_push_r, o_perf_pop_r, o_perf_err_r (32 bits each), saturating counters of successful pushes, successful pops, and overflow/underflow events. Reset to 0.
- Undefined: the counters and ports are absent.

Test Plan:
- After reset: o_cmd_rdy=0 for BANKS_N*LINES_N (256) cycles, then 1; all strobes 0 throughout.
- Push engine 0, dat=0xA5 → next cycle: DATA write at bank 0, addr 0, din=0xA5; uc head_ptr=0, tail_vld=0.
- Second push of 0xB6 to engine 0 → head_ptr=1, tail_vld=1, tail_ptr=0.
- Pop engine 0 with stubbed PREV dout=0 → read strobes at addr 1; rdy low for 2 cycles; next pop reads addr 0.
- Pop on empty engine 2 → uc vld=1, head_vld=0, no ce asserted, rdy stays 1.
- Push 257 times to one engine → 257th push yields uc head_vld=0 and no strobe; with STK_PIPE_LK_PERF_EN, o_perf_err_r=1 and o_perf_push_r=256.
